// File: rtl/rv_pkg.sv
// Shared encodings for the RV32I multi-cycle control path; the datapath and ALU
// decode the same select/op values.
package rv_pkg;

    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;
    localparam logic [6:0] OPC_JAL   = 7'b1101111;
    localparam logic [6:0] OPC_JALR  = 7'b1100111;
    localparam logic [6:0] OPC_BR    = 7'b1100011;
    localparam logic [6:0] OPC_LD    = 7'b0000011;
    localparam logic [6:0] OPC_ST    = 7'b0100011;
    localparam logic [6:0] OPC_OPI   = 7'b0010011;
    localparam logic [6:0] OPC_OP    = 7'b0110011;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_e;

    localparam logic [1:0] ALU_OP_ADD   = 2'd0;
    localparam logic [1:0] ALU_OP_RTYPE = 2'd1;
    localparam logic [1:0] ALU_OP_ITYPE = 2'd2;

    localparam logic [1:0] SRC_A_RS1  = 2'd0;
    localparam logic [1:0] SRC_A_PC   = 2'd1;
    localparam logic [1:0] SRC_A_ZERO = 2'd2;

    localparam logic SRC_B_RS2 = 1'b0;
    localparam logic SRC_B_IMM = 1'b1;

    localparam logic [1:0] WB_ALU  = 2'd0;
    localparam logic [1:0] WB_LOAD = 2'd1;
    localparam logic [1:0] WB_PC4  = 2'd2;

    localparam logic PC_SEL_PC4 = 1'b0;
    localparam logic PC_SEL_ALU = 1'b1;

    typedef struct packed {
        logic       imem_req;
        logic       ir_we;
        logic       pc_we;
        logic       pc_sel;
        logic       aluout_we;
        logic [1:0] alu_src_a;
        logic       alu_src_b;
        logic [1:0] alu_op;
        logic       rf_we;
        logic [1:0] wb_sel;
        logic       dmem_req;
        logic       dmem_we;
        logic       trap;
    } ctrl_out_t;

    // Loads allow b/h/w/bu/hu (0,1,2,4,5); stores allow b/h/w only.
    function automatic logic opc_illegal(input logic [6:0] opc, input logic [2:0] f3);
        case (opc)
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR,
            OPC_BR, OPC_OPI, OPC_OP: return 1'b0;
            OPC_LD:                  return (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
            OPC_ST:                  return (f3 >= 3'd3);
            default:                 return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/rv_multicycle_ctrl_if.sv
// Decoder/memory handshake inputs and datapath control outputs of the controller.
interface rv_multicycle_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [6:0]       OPCODE;
    logic [2:0]       FUNCT3;
    logic             BR_TAKEN;
    logic             IMEM_READY;
    logic             DMEM_READY;
    logic             IMEM_REQ;
    logic             IR_WE;
    logic             PC_WE;
    logic             PC_SEL;
    logic             ALUOUT_WE;
    logic [1:0]       ALU_SRC_A;
    logic             ALU_SRC_B;
    logic [1:0]       ALU_OP;
    logic             RF_WE;
    logic [1:0]       WB_SEL;
    logic             DMEM_REQ;
    logic             DMEM_WE;
    logic             TRAP;
    logic [CNT_W-1:0] INSTRET;

    modport master (
        input  OPCODE, FUNCT3, BR_TAKEN, IMEM_READY, DMEM_READY,
        output IMEM_REQ, IR_WE, PC_WE, PC_SEL, ALUOUT_WE, ALU_SRC_A, ALU_SRC_B,
               ALU_OP, RF_WE, WB_SEL, DMEM_REQ, DMEM_WE, TRAP, INSTRET
    );

    modport slave (
        output OPCODE, FUNCT3, BR_TAKEN, IMEM_READY, DMEM_READY,
        input  IMEM_REQ, IR_WE, PC_WE, PC_SEL, ALUOUT_WE, ALU_SRC_A, ALU_SRC_B,
               ALU_OP, RF_WE, WB_SEL, DMEM_REQ, DMEM_WE, TRAP, INSTRET
    );
endinterface

// File: rtl/rv_mem_wait_timer.sv
// Memory wait counter shared by FETCH and MEM; at_limit flags the last allowed wait cycle.
module rv_mem_wait_timer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic clr,
    input  logic inc,
    output logic at_limit
);
    localparam int CW = $clog2(MEM_TIMEOUT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // A not-ready cycle seen while at_limit is the MEM_TIMEOUT-th wait.
    assign at_limit = (cnt_q == CW'(MEM_TIMEOUT - 1));

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/rv_multicycle_ctrl.sv
// RV32I multi-cycle control FSM: sequences fetch/decode/exec/mem/writeback,
// counts retired instructions and traps permanently on faults.
module rv_multicycle_ctrl
    import rv_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input logic                  CLK,
    input logic                  RST_N,
    rv_multicycle_ctrl_if.master bus
);
    state_e           state_q, state_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    ctrl_out_t        co;
    logic             retire;
    logic             wait_inc;
    logic             wait_clr;
    logic             wait_at_limit;
    logic             is_st;

    assign is_st    = (bus.OPCODE == OPC_ST);
    assign wait_clr = (state_d != state_q);

    rv_mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wait (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .clr      (wait_clr),
        .inc      (wait_inc),
        .at_limit (wait_at_limit)
    );

    always_comb begin
        co       = '0;
        state_d  = state_q;
        retire   = 1'b0;
        wait_inc = 1'b0;
        case (state_q)
            S_FETCH: begin
                co.imem_req = 1'b1;
                wait_inc    = !bus.IMEM_READY;
                if (bus.IMEM_READY) begin
                    co.ir_we = 1'b1;
                    state_d  = S_DECODE;
                end else if (wait_at_limit) begin
                    state_d = S_TRAP;
                end
            end
            S_DECODE: begin
                co.aluout_we = 1'b1;
                co.alu_src_a = SRC_A_PC;
                co.alu_src_b = SRC_B_IMM;
                co.alu_op    = ALU_OP_ADD;
                state_d      = opc_illegal(bus.OPCODE, bus.FUNCT3) ? S_TRAP : S_EXEC;
            end
            S_EXEC: begin
                state_d = S_WB;
                case (bus.OPCODE)
                    OPC_OP: begin
                        co.aluout_we = 1'b1;
                        co.alu_src_a = SRC_A_RS1;
                        co.alu_src_b = SRC_B_RS2;
                        co.alu_op    = ALU_OP_RTYPE;
                    end
                    OPC_OPI: begin
                        co.aluout_we = 1'b1;
                        co.alu_src_a = SRC_A_RS1;
                        co.alu_src_b = SRC_B_IMM;
                        co.alu_op    = ALU_OP_ITYPE;
                    end
                    OPC_LUI: begin
                        co.aluout_we = 1'b1;
                        co.alu_src_a = SRC_A_ZERO;
                        co.alu_src_b = SRC_B_IMM;
                    end
                    OPC_AUIPC: begin
                        co.aluout_we = 1'b1;
                        co.alu_src_a = SRC_A_PC;
                        co.alu_src_b = SRC_B_IMM;
                    end
                    OPC_LD, OPC_ST, OPC_JALR: begin
                        co.aluout_we = 1'b1;
                        co.alu_src_a = SRC_A_RS1;
                        co.alu_src_b = SRC_B_IMM;
                        co.alu_op    = ALU_OP_ADD;
                        if (bus.OPCODE != OPC_JALR) begin
                            state_d = S_MEM;
                        end
                    end
                    OPC_JAL: ;  // ALU_OUT still holds the PC+IMM target from DECODE
                    OPC_BR: begin
                        co.pc_we  = 1'b1;
                        co.pc_sel = bus.BR_TAKEN;
                        retire    = 1'b1;
                        state_d   = S_FETCH;
                    end
                    default: state_d = S_TRAP;
                endcase
            end
            S_MEM: begin
                co.dmem_req = 1'b1;
                co.dmem_we  = is_st;
                wait_inc    = !bus.DMEM_READY;
                if (bus.DMEM_READY) begin
                    if (is_st) begin
                        co.pc_we  = 1'b1;
                        co.pc_sel = PC_SEL_PC4;
                        retire    = 1'b1;
                        state_d   = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (wait_at_limit) begin
                    state_d = S_TRAP;
                end
            end
            S_WB: begin
                co.rf_we = 1'b1;
                co.pc_we = 1'b1;
                retire   = 1'b1;
                state_d  = S_FETCH;
                if (bus.OPCODE == OPC_LD) begin
                    co.wb_sel = WB_LOAD;
                end else if (bus.OPCODE == OPC_JAL || bus.OPCODE == OPC_JALR) begin
                    co.wb_sel = WB_PC4;
                    co.pc_sel = PC_SEL_ALU;
                end
            end
            S_TRAP: co.trap = 1'b1;
            default: state_d = S_TRAP;
        endcase
        // Outputs drop the moment reset asserts, not at the next edge.
        if (!RST_N) begin
            co = '0;
        end
        instret_d = instret_q + {{(CNT_W-1){1'b0}}, retire};
    end

    assign bus.IMEM_REQ  = co.imem_req;
    assign bus.IR_WE     = co.ir_we;
    assign bus.PC_WE     = co.pc_we;
    assign bus.PC_SEL    = co.pc_sel;
    assign bus.ALUOUT_WE = co.aluout_we;
    assign bus.ALU_SRC_A = co.alu_src_a;
    assign bus.ALU_SRC_B = co.alu_src_b;
    assign bus.ALU_OP    = co.alu_op;
    assign bus.RF_WE     = co.rf_we;
    assign bus.WB_SEL    = co.wb_sel;
    assign bus.DMEM_REQ  = co.dmem_req;
    assign bus.DMEM_WE   = co.dmem_we;
    assign bus.TRAP      = co.trap;
    assign bus.INSTRET   = instret_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= S_FETCH;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
        end
    end

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Scoreboard bench for rv_multicycle_ctrl: each scenario queues per-cycle inputs
// with the expected control outputs and retired count, then replays and compares.
module tb_rv_multicycle_ctrl;
    import rv_pkg::*;

    localparam logic [6:0] OPC_SYS = 7'b1110011;

    typedef struct {
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic        ir;
        logic        dr;
        logic        bt;
        logic [15:0] v;
        logic [31:0] ret;
    } step_t;

    logic  CLK;
    logic  RST_N;
    step_t sbq[$];
    int    total;
    int    bad;

    rv_multicycle_ctrl_if #(.CNT_W(32)) bus ();

    rv_multicycle_ctrl #(.MEM_TIMEOUT(16), .CNT_W(32)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // {imem_req, ir_we, pc_we, pc_sel, aluout_we, src_a[2], src_b, alu_op[2], rf_we, wb_sel[2], dmem_req, dmem_we, trap}
    function automatic logic [15:0] ev(input logic imem_req, ir_we, pc_we, pc_sel, alu_we,
                                       input logic [1:0] a, input logic b, input logic [1:0] op,
                                       input logic rf_we, input logic [1:0] wb,
                                       input logic dreq, dwe, trap);
        return {imem_req, ir_we, pc_we, pc_sel, alu_we, a, b, op, rf_we, wb, dreq, dwe, trap};
    endfunction

    function automatic logic [15:0] v_fetch(input logic rdy);
        return ev(1, rdy, 0, 0, 0, 2'd0, 0, 2'd0, 0, 2'd0, 0, 0, 0);
    endfunction
    function automatic logic [15:0] v_dec();
        return ev(0, 0, 0, 0, 1, 2'd1, 1, 2'd0, 0, 2'd0, 0, 0, 0);
    endfunction
    function automatic logic [15:0] v_exec(input logic [1:0] a, input logic b, input logic [1:0] op);
        return ev(0, 0, 0, 0, 1, a, b, op, 0, 2'd0, 0, 0, 0);
    endfunction
    function automatic logic [15:0] v_br(input logic taken);
        return ev(0, 0, 1, taken, 0, 2'd0, 0, 2'd0, 0, 2'd0, 0, 0, 0);
    endfunction
    function automatic logic [15:0] v_mem(input logic st, input logic rdy);
        return ev(0, 0, st & rdy, 0, 0, 2'd0, 0, 2'd0, 0, 2'd0, 1, st, 0);
    endfunction
    function automatic logic [15:0] v_wb(input logic [1:0] wb, input logic pcsel);
        return ev(0, 0, 1, pcsel, 0, 2'd0, 0, 2'd0, 1, wb, 0, 0, 0);
    endfunction
    function automatic logic [15:0] v_trap();
        return 16'h0001;
    endfunction

    function automatic logic [15:0] obs();
        return {bus.IMEM_REQ, bus.IR_WE, bus.PC_WE, bus.PC_SEL, bus.ALUOUT_WE, bus.ALU_SRC_A,
                bus.ALU_SRC_B, bus.ALU_OP, bus.RF_WE, bus.WB_SEL, bus.DMEM_REQ, bus.DMEM_WE, bus.TRAP};
    endfunction

    task automatic push(input logic [6:0] opc, input logic [2:0] f3, input logic ir, dr, bt,
                        input logic [15:0] v, input logic [31:0] ret);
        step_t s;
        s.opc = opc; s.f3 = f3; s.ir = ir; s.dr = dr; s.bt = bt; s.v = v; s.ret = ret;
        sbq.push_back(s);
    endtask

    task automatic drive(input step_t s);
        bus.OPCODE = s.opc; bus.FUNCT3 = s.f3; bus.IMEM_READY = s.ir;
        bus.DMEM_READY = s.dr; bus.BR_TAKEN = s.bt;
        @(negedge CLK);
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        bus.IMEM_READY = 1'b0; bus.DMEM_READY = 1'b0; bus.BR_TAKEN = 1'b0;
        next_cycle();
        next_cycle();
        RST_N = 1'b1;
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        bus.OPCODE = OPC_OP; bus.FUNCT3 = 3'd0;
        bus.IMEM_READY = 1'b1; bus.DMEM_READY = 1'b1; bus.BR_TAKEN = 1'b1;
        #2;
        total++;
        if (obs() !== 16'h0 || bus.INSTRET !== 32'd0) begin
            bad++;
            $display("FAIL reset_held out=%h instret=%0d want out=0000 instret=0", obs(), bus.INSTRET);
        end
        do_reset();
        bus.IMEM_READY = 1'b0;
        @(negedge CLK);
        total++;
        if (obs() !== v_fetch(0) || bus.INSTRET !== 32'd0) begin
            bad++;
            $display("FAIL reset_fetch out=%h instret=%0d want out=%h instret=0", obs(), bus.INSTRET, v_fetch(0));
        end
        next_cycle();
    endtask

    task automatic test_alu_op();
        step_t s;
        int n = 0;
        do_reset();
        push(OPC_OP, 3'd0, 1, 1, 0, v_fetch(1), 0);
        push(OPC_OP, 3'd0, 1, 1, 0, v_dec(), 0);
        push(OPC_OP, 3'd0, 1, 1, 0, v_exec(2'd0, 0, 2'd1), 0);
        push(OPC_OP, 3'd0, 1, 1, 0, v_wb(2'd0, 0), 0);
        push(OPC_OP, 3'd0, 1, 1, 0, v_fetch(1), 1);
        while (sbq.size() != 0) begin
            s = sbq.pop_front();
            drive(s);
            total++;
            if (obs() !== s.v || bus.INSTRET !== s.ret) begin
                bad++;
                $display("FAIL alu_op[%0d] out=%h instret=%0d want out=%h instret=%0d", n, obs(), bus.INSTRET, s.v, s.ret);
            end
            next_cycle();
            n++;
        end
    endtask

    task automatic test_load_wait();
        step_t s;
        int n = 0;
        do_reset();
        push(OPC_LD, 3'd2, 1, 0, 0, v_fetch(1), 0);
        push(OPC_LD, 3'd2, 1, 0, 0, v_dec(), 0);
        push(OPC_LD, 3'd2, 1, 0, 0, v_exec(2'd0, 1, 2'd0), 0);
        for (int i = 0; i < 3; i++) push(OPC_LD, 3'd2, 1, 0, 0, v_mem(0, 0), 0);
        push(OPC_LD, 3'd2, 1, 1, 0, v_mem(0, 1), 0);
        push(OPC_LD, 3'd2, 1, 1, 0, v_wb(2'd1, 0), 0);
        push(OPC_LD, 3'd2, 1, 1, 0, v_fetch(1), 1);
        while (sbq.size() != 0) begin
            s = sbq.pop_front();
            drive(s);
            total++;
            if (obs() !== s.v || bus.INSTRET !== s.ret) begin
                bad++;
                $display("FAIL load_wait[%0d] out=%h instret=%0d want out=%h instret=%0d", n, obs(), bus.INSTRET, s.v, s.ret);
            end
            next_cycle();
            n++;
        end
    endtask

    task automatic test_branch();
        step_t s;
        int n = 0;
        do_reset();
        push(OPC_BR, 3'd0, 1, 1, 1, v_fetch(1), 0);
        push(OPC_BR, 3'd0, 1, 1, 1, v_dec(), 0);
        push(OPC_BR, 3'd0, 1, 1, 1, v_br(1), 0);
        push(OPC_BR, 3'd0, 1, 1, 0, v_fetch(1), 1);
        push(OPC_BR, 3'd0, 1, 1, 0, v_dec(), 1);
        push(OPC_BR, 3'd0, 1, 1, 0, v_br(0), 1);
        push(OPC_BR, 3'd0, 1, 1, 0, v_fetch(1), 2);
        while (sbq.size() != 0) begin
            s = sbq.pop_front();
            drive(s);
            total++;
            if (obs() !== s.v || bus.INSTRET !== s.ret) begin
                bad++;
                $display("FAIL branch[%0d] out=%h instret=%0d want out=%h instret=%0d", n, obs(), bus.INSTRET, s.v, s.ret);
            end
            next_cycle();
            n++;
        end
    endtask

    task automatic test_back_to_back();
        step_t       s;
        int          n = 0;
        logic [31:0] r = 0;
        logic [6:0]  opcs [5];
        logic [15:0] exv  [5];
        logic [15:0] wbv  [5];
        opcs[0] = OPC_OPI;   exv[0] = v_exec(2'd0, 1, 2'd2); wbv[0] = v_wb(2'd0, 0);
        opcs[1] = OPC_LUI;   exv[1] = v_exec(2'd2, 1, 2'd0); wbv[1] = v_wb(2'd0, 0);
        opcs[2] = OPC_AUIPC; exv[2] = v_exec(2'd1, 1, 2'd0); wbv[2] = v_wb(2'd0, 0);
        opcs[3] = OPC_JAL;   exv[3] = 16'h0000;              wbv[3] = v_wb(2'd2, 1);
        opcs[4] = OPC_JALR;  exv[4] = v_exec(2'd0, 1, 2'd0); wbv[4] = v_wb(2'd2, 1);
        do_reset();
        for (int i = 0; i < 5; i++) begin
            push(opcs[i], 3'd0, 1, 1, 0, v_fetch(1), r);
            push(opcs[i], 3'd0, 1, 1, 0, v_dec(), r);
            push(opcs[i], 3'd0, 1, 1, 0, exv[i], r);
            push(opcs[i], 3'd0, 1, 1, 0, wbv[i], r);
            r++;
        end
        push(OPC_ST, 3'd2, 1, 1, 0, v_fetch(1), r);
        push(OPC_ST, 3'd2, 1, 1, 0, v_dec(), r);
        push(OPC_ST, 3'd2, 1, 1, 0, v_exec(2'd0, 1, 2'd0), r);
        push(OPC_ST, 3'd2, 1, 1, 0, v_mem(1, 1), r);
        r++;
        push(OPC_LD, 3'd5, 1, 1, 0, v_fetch(1), r);
        push(OPC_LD, 3'd5, 1, 1, 0, v_dec(), r);
        push(OPC_LD, 3'd5, 1, 1, 0, v_exec(2'd0, 1, 2'd0), r);
        push(OPC_LD, 3'd5, 1, 1, 0, v_mem(0, 1), r);
        push(OPC_LD, 3'd5, 1, 1, 0, v_wb(2'd1, 0), r);
        r++;
        push(OPC_OP, 3'd0, 1, 1, 0, v_fetch(1), r);
        while (sbq.size() != 0) begin
            s = sbq.pop_front();
            drive(s);
            total++;
            if (obs() !== s.v || bus.INSTRET !== s.ret) begin
                bad++;
                $display("FAIL back_to_back[%0d] out=%h instret=%0d want out=%h instret=%0d", n, obs(), bus.INSTRET, s.v, s.ret);
            end
            next_cycle();
            n++;
        end
    endtask

    task automatic test_illegal();
        step_t      s;
        int         n = 0;
        logic [6:0] bad_opc [4];
        logic [2:0] bad_f3  [4];
        bad_opc[0] = OPC_LD; bad_f3[0] = 3'd3;
        bad_opc[1] = OPC_LD; bad_f3[1] = 3'd7;
        bad_opc[2] = OPC_ST; bad_f3[2] = 3'd3;
        bad_opc[3] = OPC_ST; bad_f3[3] = 3'd4;
        do_reset();
        push(OPC_OP, 3'd0, 1, 1, 0, v_fetch(1), 0);
        push(OPC_OP, 3'd0, 1, 1, 0, v_dec(), 0);
        push(OPC_OP, 3'd0, 1, 1, 0, v_exec(2'd0, 0, 2'd1), 0);
        push(OPC_OP, 3'd0, 1, 1, 0, v_wb(2'd0, 0), 0);
        push(OPC_SYS, 3'd0, 1, 1, 0, v_fetch(1), 1);
        push(OPC_SYS, 3'd0, 1, 1, 0, v_dec(), 1);
        for (int i = 0; i < 20; i++) push(OPC_OP, 3'd0, 1, 1, 1, v_trap(), 1);
        while (sbq.size() != 0) begin
            s = sbq.pop_front();
            drive(s);
            total++;
            if (obs() !== s.v || bus.INSTRET !== s.ret) begin
                bad++;
                $display("FAIL illegal_sys[%0d] out=%h instret=%0d want out=%h instret=%0d", n, obs(), bus.INSTRET, s.v, s.ret);
            end
            next_cycle();
            n++;
        end
        for (int k = 0; k < 4; k++) begin
            do_reset();
            push(bad_opc[k], bad_f3[k], 1, 1, 0, v_fetch(1), 0);
            push(bad_opc[k], bad_f3[k], 1, 1, 0, v_dec(), 0);
            push(bad_opc[k], bad_f3[k], 1, 1, 0, v_trap(), 0);
            push(bad_opc[k], bad_f3[k], 1, 1, 0, v_trap(), 0);
        end
        push(OPC_OP, 3'd0, 0, 0, 0, v_trap(), 0);
        n = 0;
        while (sbq.size() != 0) begin
            s = sbq.pop_front();
            if (s.v == v_fetch(1) && n != 0) do_reset();
            drive(s);
            total++;
            if (obs() !== s.v || bus.INSTRET !== s.ret) begin
                bad++;
                $display("FAIL illegal_f3[%0d] out=%h instret=%0d want out=%h instret=%0d", n, obs(), bus.INSTRET, s.v, s.ret);
            end
            next_cycle();
            n++;
        end
        // A reset pulse is the only way out of TRAP.
        do_reset();
        push(OPC_OP, 3'd0, 0, 0, 0, v_fetch(0), 0);
        push(OPC_OP, 3'd0, 1, 0, 0, v_fetch(1), 0);
        push(OPC_OP, 3'd0, 1, 0, 0, v_dec(), 0);
        n = 0;
        while (sbq.size() != 0) begin
            s = sbq.pop_front();
            drive(s);
            total++;
            if (obs() !== s.v || bus.INSTRET !== s.ret) begin
                bad++;
                $display("FAIL trap_release[%0d] out=%h instret=%0d want out=%h instret=%0d", n, obs(), bus.INSTRET, s.v, s.ret);
            end
            next_cycle();
            n++;
        end
    endtask

    task automatic test_timeout();
        step_t s;
        int    n = 0;
        do_reset();
        for (int i = 0; i < 16; i++) push(OPC_OP, 3'd0, 0, 0, 0, v_fetch(0), 0);
        for (int i = 0; i < 3; i++)  push(OPC_OP, 3'd0, 1, 1, 0, v_trap(), 0);
        while (sbq.size() != 0) begin
            s = sbq.pop_front();
            drive(s);
            total++;
            if (obs() !== s.v || bus.INSTRET !== s.ret) begin
                bad++;
                $display("FAIL imem_timeout[%0d] out=%h instret=%0d want out=%h instret=%0d", n, obs(), bus.INSTRET, s.v, s.ret);
            end
            next_cycle();
            n++;
        end
        do_reset();
        for (int i = 0; i < 14; i++) push(OPC_OP, 3'd0, 0, 0, 0, v_fetch(0), 0);
        push(OPC_OP, 3'd0, 1, 0, 0, v_fetch(1), 0);
        push(OPC_OP, 3'd0, 1, 0, 0, v_dec(), 0);
        push(OPC_OP, 3'd0, 1, 0, 0, v_exec(2'd0, 0, 2'd1), 0);
        push(OPC_OP, 3'd0, 1, 0, 0, v_wb(2'd0, 0), 0);
        push(OPC_ST, 3'd1, 1, 0, 0, v_fetch(1), 1);
        push(OPC_ST, 3'd1, 1, 0, 0, v_dec(), 1);
        push(OPC_ST, 3'd1, 1, 0, 0, v_exec(2'd0, 1, 2'd0), 1);
        for (int i = 0; i < 15; i++) push(OPC_ST, 3'd1, 1, 0, 0, v_mem(1, 0), 1);
        push(OPC_ST, 3'd1, 1, 1, 0, v_mem(1, 1), 1);
        push(OPC_LD, 3'd0, 1, 0, 0, v_fetch(1), 2);
        push(OPC_LD, 3'd0, 1, 0, 0, v_dec(), 2);
        push(OPC_LD, 3'd0, 1, 0, 0, v_exec(2'd0, 1, 2'd0), 2);
        for (int i = 0; i < 16; i++) push(OPC_LD, 3'd0, 1, 0, 0, v_mem(0, 0), 2);
        push(OPC_LD, 3'd0, 1, 1, 0, v_trap(), 2);
        push(OPC_LD, 3'd0, 1, 1, 0, v_trap(), 2);
        n = 0;
        while (sbq.size() != 0) begin
            s = sbq.pop_front();
            drive(s);
            total++;
            if (obs() !== s.v || bus.INSTRET !== s.ret) begin
                bad++;
                $display("FAIL wait_limit[%0d] out=%h instret=%0d want out=%h instret=%0d", n, obs(), bus.INSTRET, s.v, s.ret);
            end
            next_cycle();
            n++;
        end
    endtask

    task automatic test_async_reset();
        step_t s;
        int    n = 0;
        do_reset();
        push(OPC_OP, 3'd0, 1, 0, 0, v_fetch(1), 0);
        push(OPC_OP, 3'd0, 1, 0, 0, v_dec(), 0);
        push(OPC_OP, 3'd0, 1, 0, 0, v_exec(2'd0, 0, 2'd1), 0);
        push(OPC_OP, 3'd0, 1, 0, 0, v_wb(2'd0, 0), 0);
        push(OPC_ST, 3'd2, 1, 0, 0, v_fetch(1), 1);
        push(OPC_ST, 3'd2, 1, 0, 0, v_dec(), 1);
        push(OPC_ST, 3'd2, 1, 0, 0, v_exec(2'd0, 1, 2'd0), 1);
        push(OPC_ST, 3'd2, 1, 0, 0, v_mem(1, 0), 1);
        push(OPC_ST, 3'd2, 1, 0, 0, v_mem(1, 0), 1);
        while (sbq.size() != 0) begin
            s = sbq.pop_front();
            drive(s);
            total++;
            if (obs() !== s.v || bus.INSTRET !== s.ret) begin
                bad++;
                $display("FAIL async_pre[%0d] out=%h instret=%0d want out=%h instret=%0d", n, obs(), bus.INSTRET, s.v, s.ret);
            end
            next_cycle();
            n++;
        end
        #2;
        RST_N = 1'b0;
        #1;
        total++;
        if (obs() !== 16'h0000 || bus.INSTRET !== 32'd0) begin
            bad++;
            $display("FAIL async_clear out=%h instret=%0d want out=0000 instret=0", obs(), bus.INSTRET);
        end
        next_cycle();
        RST_N = 1'b1;
        push(OPC_ST, 3'd2, 1, 1, 0, v_fetch(1), 0);
        push(OPC_ST, 3'd2, 1, 1, 0, v_dec(), 0);
        n = 0;
        while (sbq.size() != 0) begin
            s = sbq.pop_front();
            drive(s);
            total++;
            if (obs() !== s.v || bus.INSTRET !== s.ret) begin
                bad++;
                $display("FAIL async_post[%0d] out=%h instret=%0d want out=%h instret=%0d", n, obs(), bus.INSTRET, s.v, s.ret);
            end
            next_cycle();
            n++;
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        RST_N = 1'b0;
        bus.OPCODE = 7'd0; bus.FUNCT3 = 3'd0; bus.BR_TAKEN = 1'b0;
        bus.IMEM_READY = 1'b0; bus.DMEM_READY = 1'b0;
        test_reset();
        test_alu_op();
        test_load_wait();
        test_branch();
        test_back_to_back();
        test_illegal();
        test_timeout();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
